// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multi-cycle controller: state codes, opcodes,
// instruction classes and datapath select encodings.
package multicycle_control_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC     = 4'd6,
    S_ALU_WB   = 4'd7,
    S_BRANCH   = 4'd8
  } state_t;

  typedef enum logic [2:0] {
    CLS_R,
    CLS_I,
    CLS_LD,
    CLS_ST,
    CLS_BR,
    CLS_ILL
  } instr_class_t;

  localparam logic [6:0] OPC_R  = 7'b0110011;
  localparam logic [6:0] OPC_I  = 7'b0010011;
  localparam logic [6:0] OPC_LD = 7'b0000011;
  localparam logic [6:0] OPC_ST = 7'b0100011;
  localparam logic [6:0] OPC_BR = 7'b1100011;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_FUNC = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

endpackage

// File: rtl/multicycle_control_opcode_class.sv
// Combinational opcode-to-instruction-class map shared by next-state and
// output decoding of the controller.
module opcode_class
  import multicycle_control_pkg::*;
#(
  parameter int OPC_W = 7
) (
  input  logic [OPC_W-1:0] opcode,
  output instr_class_t     cls
);

  always_comb begin
    cls = CLS_ILL;
    case (opcode)
      OPC_R:   cls = CLS_R;
      OPC_I:   cls = CLS_I;
      OPC_LD:  cls = CLS_LD;
      OPC_ST:  cls = CLS_ST;
      OPC_BR:  cls = CLS_BR;
      default: cls = CLS_ILL;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle main controller: sequences fetch/decode/execute/memory/
// write-back and drives datapath enables, selects and the memory handshake.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int OPC_W = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [OPC_W-1:0] opcode,
  input  logic             funct3_0,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             iord,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_src,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             illegal,
  output logic [3:0]       state
);

  state_t       cur;
  instr_class_t cls;

  opcode_class #(.OPC_W(OPC_W)) u_opcode_class (
    .opcode (opcode),
    .cls    (cls)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur <= S_FETCH;
    end else begin
      case (cur)
        S_FETCH:    if (mem_ready) cur <= S_DECODE;
        S_DECODE: begin
          case (cls)
            CLS_R, CLS_I:   cur <= S_EXEC;
            CLS_LD, CLS_ST: cur <= S_MEM_ADDR;
            CLS_BR:         cur <= S_BRANCH;
            default:        cur <= S_FETCH;
          endcase
        end
        S_MEM_ADDR: begin
          if (cls == CLS_LD)      cur <= S_MEM_RD;
          else if (cls == CLS_ST) cur <= S_MEM_WR;
          else                    cur <= S_FETCH;
        end
        S_MEM_RD:   if (mem_ready) cur <= S_MEM_WB;
        S_MEM_WB:   cur <= S_FETCH;
        S_MEM_WR:   if (mem_ready) cur <= S_FETCH;
        S_EXEC:     cur <= S_ALU_WB;
        S_ALU_WB:   cur <= S_FETCH;
        S_BRANCH:   cur <= S_FETCH;
        default:    cur <= S_FETCH;
      endcase
    end
  end

  assign state = cur;

  // Outputs decode straight from the state register so that reset kills an
  // in-flight request within the same cycle; ir_write/pc_write are Mealy.
  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RS2;
    alu_op     = ALU_ADD;
    illegal    = 1'b0;
    if (!rst) begin
      case (cur)
        S_FETCH: begin
          mem_req   = 1'b1;
          alu_src_b = SRCB_FOUR;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        S_DECODE: begin
          alu_src_a = SRCA_OLDPC;
          alu_src_b = SRCB_IMM;
          illegal   = (cls == CLS_ILL);
        end
        S_MEM_ADDR: begin
          alu_src_a = SRCA_RS1;
          alu_src_b = SRCB_IMM;
        end
        S_MEM_RD: begin
          mem_req = 1'b1;
          iord    = 1'b1;
        end
        S_MEM_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
        end
        S_MEM_WR: begin
          mem_req = 1'b1;
          mem_we  = 1'b1;
          iord    = 1'b1;
        end
        S_EXEC: begin
          alu_src_a = SRCA_RS1;
          alu_src_b = (cls == CLS_I) ? SRCB_IMM : SRCB_RS2;
          alu_op    = ALU_FUNC;
        end
        S_ALU_WB: begin
          reg_write = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a = SRCA_RS1;
          alu_src_b = SRCB_RS2;
          alu_op    = ALU_SUB;
          pc_src    = 1'b1;
          pc_write  = zero ^ funct3_0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench: a per-instruction cycle model builds the expected
// output sequence, and a compare process checks the DUT every cycle.
module tb_multicycle_control;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic       pc_src;
    logic       reg_write;
    logic       mem_to_reg;
    logic [1:0] a;
    logic [1:0] b;
    logic [1:0] op;
    logic       illegal;
    logic [3:0] st;
  } out_t;

  typedef struct {
    logic [6:0] opc;
    logic       f3;
    logic       z;
    logic       rdy;
    out_t       o;
    string      tag;
  } step_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] opcode = 7'd0;
  logic       funct3_0 = 1'b0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, mem_we, iord, ir_write, pc_write, pc_src;
  logic       reg_write, mem_to_reg, illegal;
  logic [1:0] alu_src_a, alu_src_b, alu_op;
  logic [3:0] state;
  out_t       dut_out;

  int    tests = 0;
  int    failures = 0;
  step_t sched[$];
  step_t cur_step;
  bit    chk_en = 1'b0;

  multicycle_control #(.OPC_W(7)) dut (
    .clk        (clk),
    .rst        (rst),
    .opcode     (opcode),
    .funct3_0   (funct3_0),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .iord       (iord),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .pc_src     (pc_src),
    .reg_write  (reg_write),
    .mem_to_reg (mem_to_reg),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .illegal    (illegal),
    .state      (state)
  );

  assign dut_out = {mem_req, mem_we, iord, ir_write, pc_write, pc_src,
                    reg_write, mem_to_reg, alu_src_a, alu_src_b, alu_op,
                    illegal, state};

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] got,
                             input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  always @(negedge clk) begin
    #2;
    if (chk_en) checkOutput(cur_step.tag, 32'(dut_out), 32'(cur_step.o));
  end

  function automatic out_t blank(input logic [3:0] st);
    out_t o;
    o = '0;
    o.st = st;
    return o;
  endfunction

  task automatic pushStep(input logic [6:0] opc, input logic f3, input logic z,
                          input logic rdy, input out_t o, input string tag);
    step_t s;
    s.opc = opc; s.f3 = f3; s.z = z; s.rdy = rdy; s.o = o; s.tag = tag;
    sched.push_back(s);
  endtask

  // Expected cycles of one instruction, from fetch to its last state.
  task automatic addInstr(input logic [6:0] opc, input logic f3, input logic z,
                          input int fw, input int dw, input logic spur,
                          input string nm);
    out_t o;
    bit is_r, is_i, is_ld, is_st, is_br;
    is_r  = (opc == 7'b0110011);
    is_i  = (opc == 7'b0010011);
    is_ld = (opc == 7'b0000011);
    is_st = (opc == 7'b0100011);
    is_br = (opc == 7'b1100011);
    for (int i = 0; i < fw; i++) begin
      o = blank(4'd0); o.mem_req = 1; o.b = 2'b01;
      pushStep(opc, f3, z, 1'b0, o, {nm, ".fetch_wait"});
    end
    o = blank(4'd0); o.mem_req = 1; o.b = 2'b01; o.ir_write = 1; o.pc_write = 1;
    pushStep(opc, f3, z, 1'b1, o, {nm, ".fetch"});
    o = blank(4'd1); o.a = 2'b01; o.b = 2'b10;
    o.illegal = !(is_r || is_i || is_ld || is_st || is_br);
    pushStep(opc, f3, z, spur, o, {nm, ".decode"});
    if (is_r || is_i) begin
      o = blank(4'd6); o.a = 2'b10; o.b = is_i ? 2'b10 : 2'b00; o.op = 2'b10;
      pushStep(opc, f3, z, spur, o, {nm, ".exec"});
      o = blank(4'd7); o.reg_write = 1;
      pushStep(opc, f3, z, spur, o, {nm, ".alu_wb"});
    end
    if (is_ld || is_st) begin
      o = blank(4'd2); o.a = 2'b10; o.b = 2'b10;
      pushStep(opc, f3, z, spur, o, {nm, ".mem_addr"});
      o = blank(is_ld ? 4'd3 : 4'd5); o.mem_req = 1; o.iord = 1; o.mem_we = is_st;
      for (int i = 0; i < dw; i++) pushStep(opc, f3, z, 1'b0, o, {nm, ".mem_wait"});
      pushStep(opc, f3, z, 1'b1, o, {nm, ".mem_done"});
      if (is_ld) begin
        o = blank(4'd4); o.reg_write = 1; o.mem_to_reg = 1;
        pushStep(opc, f3, z, spur, o, {nm, ".mem_wb"});
      end
    end
    if (is_br) begin
      o = blank(4'd8); o.a = 2'b10; o.b = 2'b00; o.op = 2'b01; o.pc_src = 1;
      o.pc_write = z ^ f3;
      pushStep(opc, f3, z, spur, o, {nm, ".branch"});
    end
  endtask

  // Plays the scheduled cycles into the DUT, one per clock.
  task automatic applyStimulus();
    while (sched.size() > 0) begin
      @(negedge clk);
      cur_step  = sched.pop_front();
      opcode    = cur_step.opc;
      funct3_0  = cur_step.f3;
      zero      = cur_step.z;
      mem_ready = cur_step.rdy;
      chk_en    = 1'b1;
    end
    @(negedge clk);
    chk_en    = 1'b0;
    mem_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    #2;
    checkOutput("reset_all_zero", 32'(dut_out), 32'd0);
    @(negedge clk);
    mem_ready = 1'b0;
    rst = 1'b0;
    #2;
    checkOutput("post_reset_mem_req", 32'(mem_req), 32'd1);
    checkOutput("post_reset_iord", 32'(iord), 32'd0);
    checkOutput("post_reset_state", 32'(state), 32'd0);

    addInstr(7'b0110011, 0, 0, 0, 0, 0, "rtype");
    checkOutput("latency_rtype", 32'(sched.size()), 32'd4);
    applyStimulus();

    addInstr(7'b0010011, 0, 0, 2, 0, 1, "itype_fwait_spur");
    applyStimulus();

    addInstr(7'b0000011, 0, 0, 0, 2, 0, "load_w2");
    checkOutput("latency_load_w2", 32'(sched.size()), 32'd7);
    applyStimulus();

    addInstr(7'b0100011, 0, 0, 0, 0, 0, "store");
    checkOutput("latency_store", 32'(sched.size()), 32'd4);
    applyStimulus();

    addInstr(7'b1100011, 0, 1, 0, 0, 0, "beq_z1");
    checkOutput("latency_branch", 32'(sched.size()), 32'd3);
    addInstr(7'b1100011, 1, 1, 0, 0, 1, "bne_z1");
    addInstr(7'b1100011, 1, 0, 1, 0, 0, "bne_z0");
    addInstr(7'b1100011, 0, 0, 0, 0, 0, "beq_z0");
    applyStimulus();

    addInstr(7'b1111111, 0, 0, 0, 0, 0, "illegal");
    checkOutput("latency_illegal", 32'(sched.size()), 32'd2);
    addInstr(7'b0110011, 0, 0, 0, 0, 1, "rtype_spur");
    addInstr(7'b0000011, 0, 0, 1, 0, 1, "load_w0");
    applyStimulus();

    // Store left hanging in MEM_WR, then reset arrives mid-cycle.
    addInstr(7'b0100011, 0, 0, 0, 3, 0, "store_abort");
    void'(sched.pop_back());
    applyStimulus();
    #4;
    rst = 1'b1;
    #1;
    checkOutput("abort_mem_req", 32'(mem_req), 32'd0);
    checkOutput("abort_mem_we", 32'(mem_we), 32'd0);
    checkOutput("abort_state", 32'(state), 32'd0);
    checkOutput("abort_all_zero", 32'(dut_out), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #2;
    checkOutput("rerelease_mem_req", 32'(mem_req), 32'd1);
    checkOutput("rerelease_iord", 32'(iord), 32'd0);

    addInstr(7'b0110011, 0, 0, 0, 0, 0, "rtype_after_reset");
    applyStimulus();

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
